vga_sync_gen: RTL and testbench
===============================

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
- REQ-001: The block SHALL have the port clock, input, 1 bit: the system clock; all state SHALL be updated on its rising edge.
- REQ-002: The block SHALL have the port reset_n, input, 1 bit: reset, asynchronous and active-low.
- REQ-003: The block SHALL have the port enable, input, 1 bit: when high the counters run; when low they hold.
- REQ-004: The block SHALL have the port hsync, output, 1 bit: horizontal sync, active-low.
- REQ-005: The block SHALL have the port vsync, output, 1 bit: vertical sync, active-low.
- REQ-006: The block SHALL have the port activevideo, output, 1 bit: high while the current pixel is in the visible area.
- REQ-007: The block SHALL have the port x, output, xbits (10) wide: the current horizontal pixel count.
- REQ-008: The block SHALL have the port y, output, ybits (10) wide: the current vertical line count.
- REQ-009: The block SHALL have the port pix_ce, output, 1 bit: a one-clock pulse marking each pixel advance.
- REQ-010: The block SHALL have the port frame_start, output, 1 bit: a one-clock pulse when the counters wrap to (0,0).

Function
- REQ-011: The timing SHALL be 640x480@60, using the following values:
  - horizontal: 640 visible, 16 front porch, 96 sync, 48 back porch, 800 total.
  - vertical: 480 visible, 10 front porch, 2 sync, 33 back porch, 525 total.
- REQ-012: x SHALL count 0..799; y SHALL count 0..524.
- REQ-013: On a clock where pix_ce=1 and enable=1:
  - x SHALL increment.
  - At x=799, x SHALL wrap to 0 and y SHALL increment.
  - At (799,524), both SHALL wrap to 0.
- REQ-014: hsync SHALL be 0 exactly when 656<=x<=751, and 1 otherwise.
- REQ-015: vsync SHALL be 0 exactly when 490<=y<=491, and 1 otherwise.
- REQ-016: activevideo SHALL be 1 exactly when x<640 and y<480.
- REQ-017: hsync, vsync, activevideo, x and y SHALL be registered and SHALL change on the same clock edge, always describing the same pixel; this gives zero skew between sync and coordinates.
- REQ-018: frame_start SHALL be a registered pulse, high for exactly one clock, in the clock in which the outputs first show (0,0) after (799,524).
- REQ-019: When enable=0:
  - x, y, hsync, vsync and activevideo SHALL hold their values.
  - frame_start SHALL be 0.
  - pix_ce SHALL continue to toggle per REQ-024.
- REQ-020: When enable rises, counting SHALL resume from the held position at the next pix_ce, with no skipped or repeated pixels.

Reset
- REQ-021: While reset_n=0, the block SHALL hold x=0, y=0, activevideo=1, hsync=1, vsync=1, frame_start=0, pix_ce=0 and divider=0.
- REQ-022: Assertion of reset_n SHALL take effect immediately, without a clock, including in the middle of a line or frame.
- REQ-023: After reset_n rises, the first pix_ce SHALL occur per REQ-024, and the first advance SHALL be to (1,0); no frame_start SHALL be generated at reset release.

Configuration
- REQ-024: The macro VGA_PIXDIV_EN SHALL control the pixel-rate divider:
  - Defined: a 2-bit divider counts 0..3 on every clock, and pix_ce=1 only when the divider is 3, i.e. pixel rate = clock/4 (100 MHz -> 25 MHz).
  - Undefined: the divider SHALL be absent, and pix_ce SHALL be 1 on every clock after reset release, so the pixel rate equals clock.

Structure
- REQ-025: Package vga_timing_pkg SHALL hold:
  - xbits and ybits;
  - the constants H_VISIBLE, H_FP, H_SYNC, H_BP, H_TOTAL, V_VISIBLE, V_FP, V_SYNC, V_BP and V_TOTAL;
  - the derived sync start and end constants.
- REQ-026: All comparisons SHALL use the package constants; the RTL SHALL contain no literal timing numbers.
- REQ-027: The divider SHALL be the sub-module vga_pixel_ce, with ports clock, reset_n and pix_ce; it SHALL be instantiated only under VGA_PIXDIV_EN.

Verification
- REQ-028: Reset -> With reset_n=0 held for 3 clocks, the outputs SHALL equal the values in REQ-021; with reset_n pulsed low at (300,200), the outputs SHALL return to (0,0) at once, without waiting for a clock edge.
- REQ-029: Horizontal -> Over one line, hsync SHALL be 0 for exactly 96 pixels (x=656..751), and activevideo SHALL be 1 for exactly 640 pixels per visible line.
- REQ-030: Vertical -> vsync SHALL be 0 only on lines y=490 and y=491, and activevideo SHALL be 0 for all of y=480..524.
- REQ-031: Frame -> frame_start pulses SHALL be 1,680,000 clocks apart with VGA_PIXDIV_EN defined, and 420,000 clocks apart without it, with exactly one pulse per frame.
- REQ-032: Enable -> With enable dropped at (799,10) for 50 clocks, the outputs SHALL hold; after enable rises, the next advance SHALL be to (0,11).
- REQ-033: Wrap -> At (799,524), the next advance SHALL give (0,0) with frame_start=1 for one clock, and hsync, vsync, activevideo, x and y SHALL all change on the same edge.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Timing constants and small decode helpers for the 640x480@60 VGA raster.
// Every constant used by the sync generator lives here. The constants are
// typed to the counter widths so that comparisons stay width-matched.
// -----------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int xbits = 10;
    localparam int ybits = 10;

    localparam logic [xbits-1:0] X_STEP = xbits'(1);
    localparam logic [ybits-1:0] Y_STEP = ybits'(1);

    // Horizontal timing, in pixels
    localparam logic [xbits-1:0] H_VISIBLE = xbits'(640);
    localparam logic [xbits-1:0] H_FP      = xbits'(16);
    localparam logic [xbits-1:0] H_SYNC    = xbits'(96);
    localparam logic [xbits-1:0] H_BP      = xbits'(48);
    localparam logic [xbits-1:0] H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    // Vertical timing, in lines
    localparam logic [ybits-1:0] V_VISIBLE = ybits'(480);
    localparam logic [ybits-1:0] V_FP      = ybits'(10);
    localparam logic [ybits-1:0] V_SYNC    = ybits'(2);
    localparam logic [ybits-1:0] V_BP      = ybits'(33);
    localparam logic [ybits-1:0] V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // Derived sync windows (inclusive bounds) and last counter values
    localparam logic [xbits-1:0] H_SYNC_START = H_VISIBLE + H_FP;
    localparam logic [xbits-1:0] H_SYNC_END   = H_SYNC_START + H_SYNC - X_STEP;
    localparam logic [ybits-1:0] V_SYNC_START = V_VISIBLE + V_FP;
    localparam logic [ybits-1:0] V_SYNC_END   = V_SYNC_START + V_SYNC - Y_STEP;
    localparam logic [xbits-1:0] H_LAST       = H_TOTAL - X_STEP;
    localparam logic [ybits-1:0] V_LAST       = V_TOTAL - Y_STEP;

    // Pixel-rate divider: pix_ce fires when the 2-bit divider reaches this value
    localparam logic [1:0] PIXDIV_LAST = 2'd3;

    function automatic logic in_hsync(input logic [xbits-1:0] xv);
        return (xv >= H_SYNC_START) && (xv <= H_SYNC_END);
    endfunction

    function automatic logic in_vsync(input logic [ybits-1:0] yv);
        return (yv >= V_SYNC_START) && (yv <= V_SYNC_END);
    endfunction

    function automatic logic in_active(input logic [xbits-1:0] xv,
                                       input logic [ybits-1:0] yv);
        return (xv < H_VISIBLE) && (yv < V_VISIBLE);
    endfunction

endpackage

// File: rtl/vga_pixel_ce.sv
// -----------------------------------------------------------------------------
// vga_pixel_ce
// Divide-by-4 pixel clock enable. A 2-bit divider free-runs 0..3 on every
// clock; pix_ce is high for the one clock in four where the divider is 3.
// Only instantiated by vga_sync_gen when VGA_PIXDIV_EN is defined.
//
// Ports
//   clock    in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset (divider cleared to 0)
//   pix_ce   out  one-clock pixel advance pulse
// -----------------------------------------------------------------------------
module vga_pixel_ce
    import vga_timing_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    output logic pix_ce
);

    logic [1:0] div_q;
    logic [1:0] div_d;

    assign div_d  = div_q + 2'd1;
    assign pix_ce = (div_q == PIXDIV_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= 2'd0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
// 640x480@60 VGA raster generator. x/y counters advance on each pixel
// enable while enable is high; hsync, vsync, activevideo, x and y are all
// registered from the same next-position value so they always describe the
// same pixel with zero skew. frame_start pulses for one clock in the clock
// where the outputs first show (0,0) after the last pixel of a frame.
//
// Build option
//   VGA_PIXDIV_EN  defined: pixel rate = clock/4 via vga_pixel_ce.
//                  undefined: pixel rate = clock (pix_ce high every clock
//                  after reset release).
//
// Ports
//   clock        in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   enable       in   counters run when high, hold when low
//   hsync        out  horizontal sync, active-low
//   vsync        out  vertical sync, active-low
//   activevideo  out  high inside the visible area
//   x            out  pixel column 0..799
//   y            out  line 0..524
//   pix_ce       out  one-clock pixel advance pulse
//   frame_start  out  one-clock pulse on wrap to (0,0)
// -----------------------------------------------------------------------------
module vga_sync_gen
    import vga_timing_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    output logic             hsync,
    output logic             vsync,
    output logic             activevideo,
    output logic [xbits-1:0] x,
    output logic [ybits-1:0] y,
    output logic             pix_ce,
    output logic             frame_start
);

    logic             pix_ce_w;
    logic             advance;

    logic [xbits-1:0] x_q, x_d;
    logic [ybits-1:0] y_q, y_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             active_q, active_d;
    logic             frame_start_q, frame_start_d;

`ifdef VGA_PIXDIV_EN
    vga_pixel_ce u_pixel_ce (
        .clock   (clock),
        .reset_n (reset_n),
        .pix_ce  (pix_ce_w)
    );
`else
    // Registered so pix_ce is low during reset and high from the first
    // clock after release onwards.
    logic pix_ce_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pix_ce_q <= 1'b0;
        end else begin
            pix_ce_q <= 1'b1;
        end
    end

    assign pix_ce_w = pix_ce_q;
`endif

    assign advance = pix_ce_w & enable;

    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        frame_start_d = 1'b0;
        if (advance) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                if (y_q == V_LAST) begin
                    y_d           = '0;
                    frame_start_d = 1'b1;
                end else begin
                    y_d = y_q + Y_STEP;
                end
            end else begin
                x_d = x_q + X_STEP;
            end
        end
        // Decode from the next position so the flags register on the same
        // edge as the coordinates they describe.
        hsync_d  = ~in_hsync(x_d);
        vsync_d  = ~in_vsync(y_d);
        active_d = in_active(x_d, y_d);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x_q           <= '0;
            y_q           <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            active_q      <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign activevideo = active_q;
    assign frame_start = frame_start_q;
    assign pix_ce      = pix_ce_w;

endmodule

// File: tb/tb_vga_sync_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_gen
// Scoreboard bench for vga_sync_gen. A reference model tracks the raster as a
// single pixel index (0..419999) and derives x/y/sync/active arithmetically;
// it pushes one expected output set per clock, and a monitor on the falling
// edge pops and compares. A full frame is far too long to simulate here, so
// the bench jumps the raster to interesting positions by loading the DUT's
// position registers directly while enable is low.
// -----------------------------------------------------------------------------
module tb_vga_sync_gen;

    localparam int HT = 800;
    localparam int VT = 525;
    localparam int NPIX = HT * VT;

    logic       clock;
    logic       reset_n;
    logic       enable;
    logic       hsync, vsync, activevideo, pix_ce, frame_start;
    logic [9:0] x, y;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       av;
        logic       fs;
        logic       ce;
    } obs_t;

    obs_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    int m_n = 0;
    int m_k = 0;
    int preload_seq = 0;
    int preload_n   = 0;

    vga_sync_gen dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .hsync       (hsync),
        .vsync       (vsync),
        .activevideo (activevideo),
        .x           (x),
        .y           (y),
        .pix_ce      (pix_ce),
        .frame_start (frame_start)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Pixel-enable level after k clock edges since reset release
    function automatic bit pce_of(input int k);
`ifdef VGA_PIXDIV_EN
        return (k % 4) == 3;
`else
        return k >= 1;
`endif
    endfunction

    function automatic obs_t make_obs(input int n, input bit fs, input bit ce);
        obs_t o;
        int xv, yv;
        xv   = n % HT;
        yv   = n / HT;
        o.x  = 10'(xv);
        o.y  = 10'(yv);
        o.hs = !(xv >= 656 && xv <= 751);
        o.vs = !(yv >= 490 && yv <= 491);
        o.av = (xv < 640) && (yv < 480);
        o.fs = fs;
        o.ce = ce;
        return o;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    endtask

    // Reference model
    initial begin : model
        int seen;
        bit fs;
        seen = 0;
        forever begin
            @(posedge clock);
            fs = 1'b0;
            if (!reset_n) begin
                m_n = 0;
                m_k = 0;
            end else begin
                if (preload_seq != seen) begin
                    seen = preload_seq;
                    m_n  = preload_n;
                end
                if (pce_of(m_k) && enable) begin
                    fs  = (m_n == NPIX - 1);
                    m_n = (m_n + 1) % NPIX;
                end
                m_k++;
            end
            exp_q.push_back(make_obs(m_n, fs, reset_n && pce_of(m_k)));
        end
    end

    // Monitor
    initial begin : monitor
        obs_t act, e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {x, y, hsync, vsync, activevideo, frame_start, pix_ce};
                n_checks++;
                if (act === e) n_pass++;
                else $display("FAIL outputs t=%0t got x=%0d y=%0d hs=%b vs=%b av=%b fs=%b ce=%b expected x=%0d y=%0d hs=%b vs=%b av=%b fs=%b ce=%b",
                              $time, act.x, act.y, act.hs, act.vs, act.av, act.fs, act.ce,
                              e.x, e.y, e.hs, e.vs, e.av, e.fs, e.ce);
            end
        end
    end

    task automatic tick();
        @(negedge clock);
        #2;
    endtask

    // Jump the raster to (px,py); enable is dropped so the next edge holds it.
    task automatic preload(input int px, input int py);
        obs_t o;
        enable = 1'b0;
        o = make_obs(py * HT + px, 1'b0, 1'b0);
        dut.x_q      <= o.x;
        dut.y_q      <= o.y;
        dut.hsync_q  <= o.hs;
        dut.vsync_q  <= o.vs;
        dut.active_q <= o.av;
        preload_n = py * HT + px;
        preload_seq++;
        tick();
    endtask

    task automatic run_random(input int cycles, input int dip);
        for (int i = 0; i < cycles; i++) begin
            enable = ($urandom_range(0, 99) >= dip);
            tick();
        end
    endtask

    initial begin : driver
        int px_list[7];
        int py_list[7];
        int g, hs_cnt, av_cnt, fs_cnt;
        logic [9:0] prev_x;

        reset_n = 1'b0;
        enable  = 1'b0;
        repeat (3) @(posedge clock);
        tick();
        reset_n = 1'b1;
        enable  = 1'b1;
        repeat (20) tick();
        run_random(300, 30);

        // Boundary positions: sync edges, visible-area edges, line/frame wraps
        px_list = '{650, 745, 795, 795, 795, 630, 795};
        py_list = '{10, 100, 479, 489, 491, 479, 524};
        for (int i = 0; i < 7; i++) begin
            preload(px_list[i], py_list[i]);
            run_random(80, 20);
        end

        // Hold at (799,10) for 50 clocks, then the next advance must be (0,11)
        preload(795, 10);
        enable = 1'b1;
        g = 0;
        while (m_n != 10 * HT + 799 && g < 64) begin
            tick();
            g++;
        end
        check("reach_799_10", 64'(g < 64), 64'd1);
        enable = 1'b0;
        repeat (50) tick();
        enable = 1'b1;
        g = 0;
        while (x == 10'd799 && g < 16) begin
            tick();
            g++;
        end
        check("resume_x", 64'(x), 64'd0);
        check("resume_y", 64'(y), 64'd11);

        // One full visible line: count distinct pixels with hsync low / active high
        preload(0, 5);
        enable = 1'b1;
        prev_x = 10'd0;
        hs_cnt = 0;
        av_cnt = 1;
        g = 0;
        while (!(x == 10'd0 && y == 10'd6) && g < 4 * HT + 40) begin
            tick();
            g++;
            if (x != prev_x && y == 10'd5) begin
                if (!hsync) hs_cnt++;
                if (activevideo) av_cnt++;
            end
            prev_x = x;
        end
        check("line_done", 64'(g < 4 * HT + 40), 64'd1);
        check("hsync_low_pixels", 64'(hs_cnt), 64'd96);
        check("active_pixels", 64'(av_cnt), 64'd640);

        // Frame wrap: exactly one frame_start pulse
        preload(797, 524);
        enable = 1'b1;
        fs_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (frame_start) fs_cnt++;
        end
        check("frame_start_pulses", 64'(fs_cnt), 64'd1);

        // Asynchronous reset in the middle of a frame
        preload(300, 200);
        tick();
        check("pre_reset_x", 64'(x), 64'd300);
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs",
              64'({x, y, hsync, vsync, activevideo, frame_start, pix_ce}),
              64'(make_obs(0, 1'b0, 1'b0)));
        repeat (2) tick();
        reset_n = 1'b1;
        enable  = 1'b1;
        repeat (20) tick();
        run_random(200, 50);

        enable = 1'b0;
        tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
